// File: rtl/l1_l2_arbiter_if.sv
// Purpose: bundles the I-cache, D-cache and L2 handshake/bus signals of the L1->L2 arbiter.
// Ports: I side (read_I_L2/address_I -> ready_L2_I/read_data_L2_I), D side (read/write_D_L2,
//        address_D, write_data_D_L2 -> ready_L2_D/read_data_L2_D), L2 side (strobes, address,
//        write data -> ready_L2_L1/read_data_L2_L1). master = L1s+L2 environment, slave = arbiter.
interface l1_l2_arbiter_if;
  // I-cache requester
  logic         read_I_L2;
  logic [57:0]  address_I;
  logic         ready_L2_I;
  logic [511:0] read_data_L2_I;
  // D-cache requester
  logic         read_D_L2;
  logic         write_D_L2;
  logic [57:0]  address_D;
  logic [511:0] write_data_D_L2;
  logic         ready_L2_D;
  logic [511:0] read_data_L2_D;
  // L2 port
  logic         read_L1_L2;
  logic         write_L1_L2;
  logic [57:0]  address_L1_L2;
  logic [511:0] write_data_L1_L2;
  logic         ready_L2_L1;
  logic [511:0] read_data_L2_L1;

  modport master (
    output read_I_L2, address_I,
    output read_D_L2, write_D_L2, address_D, write_data_D_L2,
    output ready_L2_L1, read_data_L2_L1,
    input  ready_L2_I, read_data_L2_I, ready_L2_D, read_data_L2_D,
    input  read_L1_L2, write_L1_L2, address_L1_L2, write_data_L1_L2
  );

  modport slave (
    input  read_I_L2, address_I,
    input  read_D_L2, write_D_L2, address_D, write_data_D_L2,
    input  ready_L2_L1, read_data_L2_L1,
    output ready_L2_I, read_data_L2_I, ready_L2_D, read_data_L2_D,
    output read_L1_L2, write_L1_L2, address_L1_L2, write_data_L1_L2
  );
endinterface

// File: rtl/l1_l2_arbiter.sv
// Purpose: arbitrates I-cache and D-cache line requests onto a single L2 port, one at a time.
// Latency: L2 strobes rise one cycle after the request is sampled; ready returns combinationally
//          with ready_L2_L1, followed by one DONE cycle. Backpressure: requesters hold until ready.
// Ports: clk, nrst (sync, active-low), bus (slave modport), err_timeout (sticky L2 timeout flag).
module l1_l2_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            nrst,
  l1_l2_arbiter_if.slave  bus,
  output logic            err_timeout
);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, DONE} state_t;

  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;

  state_t       state_q, state_d;
  logic         last_grant_q, last_grant_d;
  logic [57:0]  addr_q, addr_d;
  logic [511:0] wdata_q, wdata_d;
  logic         rd_q, rd_d;
  logic         wr_q, wr_d;
  logic [15:0]  cnt_q, cnt_d;
  logic         err_q, err_d;
  logic         ready_i, ready_d;
  logic         i_req, d_req, pick_i, pick_d;
  logic [16:0]  cnt_inc;

  assign i_req   = bus.read_I_L2;
  assign d_req   = bus.read_D_L2 | bus.write_D_L2;
  // On a tie the side that did not win last time is served.
  assign pick_d  = d_req & (~i_req | (last_grant_q == GRANT_I));
  assign pick_i  = i_req & ~pick_d;
  assign cnt_inc = {1'b0, cnt_q} + 17'd1;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rd_d         = rd_q;
    wr_d         = wr_q;
    cnt_d        = cnt_q;
    err_d        = err_q;
    ready_i      = 1'b0;
    ready_d      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (pick_i) begin
          state_d      = BUSY_I;
          last_grant_d = GRANT_I;
          addr_d       = bus.address_I;
          rd_d         = 1'b1;
          wr_d         = 1'b0;
          cnt_d        = 16'd0;
        end else if (pick_d) begin
          state_d      = BUSY_D;
          last_grant_d = GRANT_D;
          addr_d       = bus.address_D;
          // A combined write+read goes out as the write; the read is re-arbitrated later.
          rd_d         = ~bus.write_D_L2;
          wr_d         = bus.write_D_L2;
          if (bus.write_D_L2) wdata_d = bus.write_data_D_L2;
          cnt_d        = 16'd0;
        end
      end
      BUSY_I, BUSY_D: begin
        if (bus.ready_L2_L1) begin
          ready_i = (state_q == BUSY_I);
          ready_d = (state_q == BUSY_D);
          state_d = DONE;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
        end else begin
          if (cnt_q != 16'hFFFF) cnt_d = cnt_inc[15:0];
          // Flag is set by the edge at which the wait count reaches TIMEOUT; the
          // transaction keeps waiting for L2.
          if (cnt_inc >= 17'(TIMEOUT)) err_d = 1'b1;
        end
      end
      DONE: begin
        // Dead cycle lets the requester drop its request before arbitration resumes.
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q      <= IDLE;
      last_grant_q <= GRANT_D;
      addr_q       <= '0;
      wdata_q      <= '0;
      rd_q         <= 1'b0;
      wr_q         <= 1'b0;
      cnt_q        <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rd_q         <= rd_d;
      wr_q         <= wr_d;
      cnt_q        <= cnt_d;
      err_q        <= err_d;
    end
  end

  assign bus.read_L1_L2       = rd_q;
  assign bus.write_L1_L2      = wr_q;
  assign bus.address_L1_L2    = addr_q;
  assign bus.write_data_L1_L2 = wdata_q;
  assign bus.ready_L2_I       = ready_i;
  assign bus.ready_L2_D       = ready_d;
  assign bus.read_data_L2_I   = bus.read_data_L2_L1;
  assign bus.read_data_L2_D   = bus.read_data_L2_L1;
  assign err_timeout          = err_q;

endmodule

// File: tb/tb_l1_l2_arbiter.sv
module tb_l1_l2_arbiter;
  logic clk;
  logic nrst;
  logic err_timeout;
  int   checks;
  int   errors;

  l1_l2_arbiter_if bus();

  l1_l2_arbiter #(.TIMEOUT(4)) dut (
    .clk         (clk),
    .nrst        (nrst),
    .bus         (bus),
    .err_timeout (err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs are driven 1 time unit after a rising edge, outputs sampled 1 unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.read_I_L2       = 1'b0;
    bus.address_I       = '0;
    bus.read_D_L2       = 1'b0;
    bus.write_D_L2      = 1'b0;
    bus.address_D       = '0;
    bus.write_data_D_L2 = '0;
    bus.ready_L2_L1     = 1'b0;
    bus.read_data_L2_L1 = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    nrst = 1'b0;
    step();
    step();
    nrst = 1'b1;
  endtask

  task automatic test_reset();
    clear_inputs();
    nrst = 1'b0;
    bus.ready_L2_L1 = 1'b1;
    step();
    step();
    #1;
    checks++;
    if (bus.read_L1_L2 !== 1'b0 || bus.write_L1_L2 !== 1'b0) begin
      errors++;
      $display("FAIL reset_strobes: got rd=%b wr=%b want 0 0", bus.read_L1_L2, bus.write_L1_L2);
    end
    checks++;
    if (bus.ready_L2_I !== 1'b0 || bus.ready_L2_D !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready: got I=%b D=%b want 0 0", bus.ready_L2_I, bus.ready_L2_D);
    end
    checks++;
    if (bus.address_L1_L2 !== 58'h0 || bus.write_data_L1_L2 !== 512'h0) begin
      errors++;
      $display("FAIL reset_latches: got addr=%h want 0", bus.address_L1_L2);
    end
    checks++;
    if (err_timeout !== 1'b0) begin
      errors++;
      $display("FAIL reset_err: got %b want 0", err_timeout);
    end
    bus.ready_L2_L1 = 1'b0;
    nrst = 1'b1;
  endtask

  task automatic test_basic_i();
    int rd_cycles;
    logic [511:0] line;
    line = {8{64'hDEAD_BEEF_0123_4567}};
    do_reset();
    bus.read_I_L2 = 1'b1;
    bus.address_I = 58'h1234;
    rd_cycles = 0;
    for (int k = 1; k <= 4; k++) begin
      step();
      if (k == 2) bus.address_I = 58'h9999; // live change must not leak through
      if (k == 4) begin
        bus.ready_L2_L1     = 1'b1;
        bus.read_data_L2_L1 = line;
      end
      #1;
      if (bus.read_L1_L2 === 1'b1) rd_cycles++;
      checks++;
      if (bus.address_L1_L2 !== 58'h1234) begin
        errors++;
        $display("FAIL basic_addr cycle %0d: got %h want 1234", k, bus.address_L1_L2);
      end
      checks++;
      if (bus.ready_L2_I !== (k == 4)) begin
        errors++;
        $display("FAIL basic_ready_i cycle %0d: got %b want %b", k, bus.ready_L2_I, k == 4);
      end
    end
    checks++;
    if (bus.read_data_L2_I !== line || bus.ready_L2_D !== 1'b0) begin
      errors++;
      $display("FAIL basic_data: got %h readyD=%b want %h 0", bus.read_data_L2_I, bus.ready_L2_D, line);
    end
    // DONE: ready still high from L2 must be ignored, request still held
    step();
    #1;
    checks++;
    if (bus.ready_L2_I !== 1'b0 || bus.read_L1_L2 !== 1'b0) begin
      errors++;
      $display("FAIL basic_done: got ready=%b rd=%b want 0 0", bus.ready_L2_I, bus.read_L1_L2);
    end
    bus.ready_L2_L1 = 1'b0;
    step();
    bus.read_I_L2 = 1'b0; // dropped one cycle after ready
    step();
    step();
    #1;
    if (bus.read_L1_L2 === 1'b1) rd_cycles++;
    checks++;
    if (rd_cycles !== 4) begin
      errors++;
      $display("FAIL basic_rd_cycles: got %0d want 4", rd_cycles);
    end
    checks++;
    if (err_timeout !== 1'b0) begin
      errors++;
      $display("FAIL basic_no_timeout: got %b want 0", err_timeout);
    end
  endtask

  task automatic test_arbitration();
    logic [57:0] want_addr;
    logic        want_d;
    do_reset();
    bus.read_I_L2 = 1'b1;
    bus.address_I = 58'h0A1;
    bus.read_D_L2 = 1'b1;
    bus.address_D = 58'h0B1;
    for (int g = 0; g < 4; g++) begin
      want_d    = (g % 2) == 1;
      want_addr = want_d ? 58'h0B1 : 58'h0A1;
      step();
      #1;
      checks++;
      if (bus.read_L1_L2 !== 1'b1 || bus.address_L1_L2 !== want_addr) begin
        errors++;
        $display("FAIL arb_grant %0d: got rd=%b addr=%h want 1 %h", g, bus.read_L1_L2, bus.address_L1_L2, want_addr);
      end
      bus.ready_L2_L1 = 1'b1;
      #1;
      checks++;
      if (bus.ready_L2_I !== !want_d || bus.ready_L2_D !== want_d) begin
        errors++;
        $display("FAIL arb_ready %0d: got I=%b D=%b want %b %b", g, bus.ready_L2_I, bus.ready_L2_D, !want_d, want_d);
      end
      step();
      bus.ready_L2_L1 = 1'b0;
      step();
      #1;
      checks++;
      if (bus.read_L1_L2 !== 1'b0) begin
        errors++;
        $display("FAIL arb_idle %0d: got rd=%b want 0", g, bus.read_L1_L2);
      end
    end
    clear_inputs();
  endtask

  task automatic test_write_then_read();
    logic [511:0] wline;
    wline = {64{8'hA5}};
    do_reset();
    bus.read_D_L2       = 1'b1;
    bus.write_D_L2      = 1'b1;
    bus.address_D       = 58'h3C0;
    bus.write_data_D_L2 = wline;
    step();
    bus.write_data_D_L2 = '0; // live change after grant
    #1;
    checks++;
    if (bus.write_L1_L2 !== 1'b1 || bus.read_L1_L2 !== 1'b0) begin
      errors++;
      $display("FAIL wr_first_strobes: got wr=%b rd=%b want 1 0", bus.write_L1_L2, bus.read_L1_L2);
    end
    checks++;
    if (bus.write_data_L1_L2 !== wline || bus.address_L1_L2 !== 58'h3C0) begin
      errors++;
      $display("FAIL wr_first_data: got %h want %h", bus.write_data_L1_L2, wline);
    end
    bus.ready_L2_L1 = 1'b1;
    #1;
    checks++;
    if (bus.ready_L2_D !== 1'b1) begin
      errors++;
      $display("FAIL wr_ready_d: got %b want 1", bus.ready_L2_D);
    end
    step();
    bus.ready_L2_L1 = 1'b0;
    bus.write_D_L2  = 1'b0;
    step();
    step();
    #1;
    checks++;
    if (bus.read_L1_L2 !== 1'b1 || bus.write_L1_L2 !== 1'b0) begin
      errors++;
      $display("FAIL rd_later: got rd=%b wr=%b want 1 0", bus.read_L1_L2, bus.write_L1_L2);
    end
    bus.ready_L2_L1 = 1'b1;
    step();
    clear_inputs();
    step();
  endtask

  task automatic test_idle_ready();
    do_reset();
    bus.ready_L2_L1     = 1'b1;
    bus.read_data_L2_L1 = {16{32'hCAFE_F00D}};
    #1;
    checks++;
    if (bus.ready_L2_I !== 1'b0 || bus.ready_L2_D !== 1'b0) begin
      errors++;
      $display("FAIL idle_ready: got I=%b D=%b want 0 0", bus.ready_L2_I, bus.ready_L2_D);
    end
    step();
    #1;
    checks++;
    if (bus.read_L1_L2 !== 1'b0 || bus.write_L1_L2 !== 1'b0 || bus.ready_L2_I !== 1'b0 || bus.ready_L2_D !== 1'b0) begin
      errors++;
      $display("FAIL idle_stay: got rd=%b wr=%b I=%b D=%b want 0 0 0 0", bus.read_L1_L2, bus.write_L1_L2, bus.ready_L2_I, bus.ready_L2_D);
    end
    clear_inputs();
  endtask

  task automatic test_timeout();
    do_reset();
    bus.read_I_L2 = 1'b1;
    bus.address_I = 58'h77;
    // Six BUSY cycles with no ready; the edge closing the 4th sets the flag.
    for (int k = 1; k <= 6; k++) begin
      step();
      #1;
      checks++;
      if (err_timeout !== (k >= 5)) begin
        errors++;
        $display("FAIL timeout_busy %0d: got %b want %b", k, err_timeout, k >= 5);
      end
    end
    checks++;
    if (bus.read_L1_L2 !== 1'b1) begin
      errors++;
      $display("FAIL timeout_not_aborted: got rd=%b want 1", bus.read_L1_L2);
    end
    step();
    bus.ready_L2_L1 = 1'b1;
    step();
    bus.ready_L2_L1 = 1'b0;
    bus.read_I_L2   = 1'b0;
    step();
    step();
    #1;
    checks++;
    if (err_timeout !== 1'b1) begin
      errors++;
      $display("FAIL timeout_sticky: got %b want 1", err_timeout);
    end
    nrst = 1'b0;
    step();
    #1;
    checks++;
    if (err_timeout !== 1'b0) begin
      errors++;
      $display("FAIL timeout_cleared: got %b want 0", err_timeout);
    end
    nrst = 1'b1;
  endtask

  task automatic test_reset_mid_busy();
    do_reset();
    bus.read_D_L2 = 1'b1;
    bus.address_D = 58'h5A5;
    step();
    #1;
    checks++;
    if (bus.read_L1_L2 !== 1'b1) begin
      errors++;
      $display("FAIL midrst_busy: got rd=%b want 1", bus.read_L1_L2);
    end
    nrst = 1'b0;
    step();
    #1;
    checks++;
    if (bus.read_L1_L2 !== 1'b0 || bus.write_L1_L2 !== 1'b0 || bus.address_L1_L2 !== 58'h0 || err_timeout !== 1'b0) begin
      errors++;
      $display("FAIL midrst_outputs: got rd=%b wr=%b addr=%h err=%b want 0 0 0 0", bus.read_L1_L2, bus.write_L1_L2, bus.address_L1_L2, err_timeout);
    end
    nrst = 1'b1;
    bus.read_D_L2   = 1'b0;
    bus.ready_L2_L1 = 1'b1;
    #1;
    checks++;
    if (bus.ready_L2_D !== 1'b0 || bus.ready_L2_I !== 1'b0) begin
      errors++;
      $display("FAIL midrst_late_ready: got D=%b I=%b want 0 0", bus.ready_L2_D, bus.ready_L2_I);
    end
    step();
    #1;
    checks++;
    if (bus.ready_L2_D !== 1'b0 || bus.read_L1_L2 !== 1'b0) begin
      errors++;
      $display("FAIL midrst_idle: got D=%b rd=%b want 0 0", bus.ready_L2_D, bus.read_L1_L2);
    end
    clear_inputs();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    nrst   = 1'b0;
    clear_inputs();
    test_reset();
    test_basic_i();
    test_arbitration();
    test_write_then_read();
    test_idle_ready();
    test_timeout();
    test_reset_mid_busy();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule

// File: doc/l1_l2_arbiter.md
L1_L2_ARBITER -- requirements
Module: l1_l2_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, meaning the number of BUSY cycles without ready_L2_L1 before err_timeout sets (range 1..65535).
REQ-002 SHALL have clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have nrst  input  1  reset, synchronous, active-low.
REQ-004 SHALL have read_I_L2  input  1  I-cache line-fill request, held high until ready_L2_I.
REQ-005 SHALL have address_I  input  58  I-cache line address (address[63:6]).
REQ-006 SHALL have read_D_L2 / write_D_L2  input  1 each  D-cache fill / write-back request, held until ready_L2_D.
REQ-007 SHALL have address_D  input  58  D-cache line address; write_data_D_L2  input  512  write-back line.
REQ-008 SHALL have read_L1_L2 / write_L1_L2  output  1 each  request strobes to L2.
REQ-009 SHALL have address_L1_L2  output  58 and write_data_L1_L2  output  512, presented to L2.
REQ-010 SHALL have ready_L2_L1  input  1 and read_data_L2_L1  input  512, L2 completion and fill line.
REQ-011 SHALL have ready_L2_I, ready_L2_D  output  1 each  completion to the granted requester.
REQ-012 SHALL have read_data_L2_I, read_data_L2_D  output  512 each  fill data to each requester.
REQ-013 SHALL have err_timeout  output  1  sticky L2-response timeout flag.

Function
REQ-014 SHALL implement FSM states IDLE, BUSY_I, BUSY_D, DONE.
REQ-015 IDLE: only I requesting -> BUSY_I; only D requesting -> BUSY_D; both -> grant the side not in last_grant; none -> stay.
REQ-016 last_grant SHALL update to the granted side on every IDLE->BUSY transition.
REQ-017 On grant, address, op type and (D write) write data SHALL be latched; outputs SHALL be driven from the latches, not from live inputs.
REQ-018 read_L1_L2 / write_L1_L2 SHALL be registered, high exactly during BUSY_x, first high one cycle after the request is sampled in IDLE.
REQ-019 D with read_D_L2 and write_D_L2 both high SHALL be issued as a write only; the read stays pending for a later grant.
REQ-020 In BUSY_x, ready_L2_L1 high SHALL assert ready_L2_x combinationally in the same cycle; next state DONE.
REQ-021 read_data_L2_I/D SHALL be combinational copies of read_data_L2_L1, valid when the matching ready is high.
REQ-022 ready_L2_L1 in IDLE or DONE SHALL be ignored; ready outputs stay 0.
REQ-023 DONE SHALL last exactly one cycle, all L2 strobes 0, no arbitration; then IDLE, so a requester dropping its request one cycle after ready is not re-granted.
REQ-024 A 16-bit wait counter SHALL clear on entry to BUSY_x, increment each BUSY cycle without ready, and saturate.
REQ-025 When the counter reaches TIMEOUT, err_timeout SHALL set and remain set until reset; the transaction is not aborted.
REQ-026 Requests changing while BUSY SHALL not affect the in-flight transaction.

Reset
REQ-027 With nrst low at a clock edge: state IDLE, all strobes and ready outputs 0, address/write data latches 0, last_grant = D, counter 0, err_timeout 0.
REQ-028 Reset mid-BUSY SHALL abandon the transaction; a late ready_L2_L1 after reset SHALL be ignored.

Verification
REQ-029 I only, address_I=58'h1234, ready after 3 cycles -> read_L1_L2 high 4 cycles, address_L1_L2=58'h1234, ready_L2_I one cycle with data.
REQ-030 I and D read same cycle after reset -> I granted first, D granted after DONE; alternation continues on repeated ties.
REQ-031 D write+read together, write_data_D_L2=512'hA5.. -> write_L1_L2 with that data first, read issued in a later grant.
REQ-032 ready_L2_L1 pulsed in IDLE -> no ready_L2_I/D, no state change.
REQ-033 TIMEOUT=4, no ready for 6 cycles -> err_timeout rises on 4th BUSY cycle, stays high after completion until nrst low.
REQ-034 nrst low during BUSY_D -> next cycle all outputs 0, state IDLE, subsequent ready ignored.
